// File: rtl/mem_bus_if.sv
// Memory bus interface: hands one controller request at a time to a RAM with a
// variable ack latency, aborts stalled accesses after TIMEOUT cycles, and raises a sticky error flag.
module mem_bus_if #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic [7:0] rdata,
  output logic       bus_ready,
  output logic       busy,
  output logic       bus_err,
  input  logic       err_clr,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_re,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  logic [1:0] r_state;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_we;
  logic [3:0] r_wait_cnt;
  logic [7:0] r_rdata;
  logic       r_bus_err;
  logic       w_in_access;
  logic       w_timeout;

  assign w_in_access = (r_state == S_ACCESS);
  // An ack on the last allowed cycle still counts as a normal completion.
  assign w_timeout   = w_in_access && !mem_ack && (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= 8'h00;
      r_wdata    <= 8'h00;
      r_we       <= 1'b0;
      r_wait_cnt <= 4'd0;
      r_rdata    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_we       <= req_we;
            r_wait_cnt <= 4'd0;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            if (!r_we) r_rdata <= mem_rdata;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            // Aborted reads return 0x00 so the controller decodes a NOP.
            if (!r_we) r_rdata <= 8'h00;
            r_state <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_bus_err <= 1'b1;
    end else if (err_clr) begin
      r_bus_err <= 1'b0;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_ACCESS) || (r_state == S_DONE);
  assign bus_ready = (r_state == S_DONE);
  assign bus_err   = r_bus_err;
  assign rdata     = r_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_re    = w_in_access && !r_we;
  assign mem_we    = w_in_access && r_we;

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: table of accesses with a RAM responder, expected
// completions held in a scoreboard queue, plus reset and idle corner sequences.
module tb_mem_bus_if;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic [7:0] rdata;
  logic       bus_ready;
  logic       busy;
  logic       bus_err;
  logic       err_clr;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_re;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  int checks = 0;
  int errors = 0;

  localparam int NEVER = 99;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         ack_after;
    logic [7:0] ram_data;
    logic       pre_clr;
    logic       clr_hold;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_cycles;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cycles;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  mem_bus_if #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rdata     (rdata),
    .bus_ready (bus_ready),
    .busy      (busy),
    .bus_err   (bus_err),
    .err_clr   (err_clr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    int   cyc;
    int   guard;
    bit   seen;
    e.rdata  = v.exp_rdata;
    e.err    = v.exp_err;
    e.cycles = v.exp_cycles;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_idle", req_ready, 1);
    if (v.pre_clr) begin
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr_clears", bus_err, 0);
    end
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    err_clr   = v.clr_hold;
    mem_rdata = v.ram_data;
    mem_ack   = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    // Scramble the request bus so only latched values can reach the RAM side.
    req_valid = 1'b0;
    req_we    = ~v.we;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      if (bus_ready === 1'b1) begin
        seen = 1;
      end else begin
        chk("busy_access", busy, 1);
        chk("req_ready_access", req_ready, 0);
        chk("mem_re", mem_re, !v.we);
        chk("mem_we", mem_we, v.we);
        chk("mem_addr_stable", mem_addr, v.addr);
        chk("mem_wdata_stable", mem_wdata, v.wdata);
        mem_ack = (cyc == v.ack_after);
        cyc++;
        @(negedge clk);
      end
    end
    chk("bus_ready_seen", seen, 1);
    mem_ack = 1'b0;
    err_clr = 1'b0;
    got = sb.pop_front();
    chk("rdata", rdata, got.rdata);
    chk("bus_err", bus_err, got.err);
    chk("access_cycles", cyc, got.cycles);
    chk("strobes_low_done", {mem_re, mem_we}, 0);
    chk("busy_done", busy, 1);
    @(negedge clk);
    chk("bus_ready_one_cycle", bus_ready, 0);
    chk("req_ready_after", req_ready, 1);
    chk("busy_after", busy, 0);
    $display("TXN %0d we=%0b addr=%02h rdata=%02h err=%0b cycles=%0d", idx, v.we, v.addr, rdata, bus_err, cyc);
  endtask

  initial begin
    vec_t post;
    int   g;
    vecs[0] = '{1'b0, 8'h10, 8'h00, 0,     8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 1};
    vecs[1] = '{1'b0, 8'h20, 8'h00, 3,     8'h40, 1'b0, 1'b0, 8'h40, 1'b0, 4};
    vecs[2] = '{1'b1, 8'hFE, 8'hA5, 1,     8'h11, 1'b0, 1'b0, 8'h40, 1'b0, 2};
    vecs[3] = '{1'b0, 8'h33, 8'h00, 14,    8'h77, 1'b0, 1'b0, 8'h77, 1'b0, 15};
    vecs[4] = '{1'b0, 8'h44, 8'h00, NEVER, 8'h99, 1'b0, 1'b0, 8'h00, 1'b1, 15};
    vecs[5] = '{1'b1, 8'h55, 8'h5A, 2,     8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 3};
    vecs[6] = '{1'b0, 8'h66, 8'h00, 0,     8'hC3, 1'b0, 1'b0, 8'hC3, 1'b1, 1};
    vecs[7] = '{1'b1, 8'h77, 8'h12, NEVER, 8'h33, 1'b1, 1'b0, 8'hC3, 1'b1, 15};
    vecs[8] = '{1'b0, 8'h88, 8'h00, NEVER, 8'h44, 1'b0, 1'b1, 8'h00, 1'b1, 15};
    vecs[9] = '{1'b0, 8'h99, 8'h00, 0,     8'h5E, 1'b1, 1'b0, 8'h5E, 1'b0, 1};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    err_clr   = 1'b0;
    mem_rdata = 8'h00;
    mem_ack   = 1'b0;
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_ready", bus_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_strobes", {mem_re, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready", req_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // RAM acks while idle must not start anything or disturb rdata.
    mem_rdata = 8'hEE;
    mem_ack   = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_bus_ready", bus_ready, 0);
    chk("idle_ack_rdata", rdata, 8'h5E);
    mem_ack = 1'b0;

    // Reset in the second ACCESS cycle of a read.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'hAB;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_rst_re_c1", mem_re, 1);
    @(negedge clk);
    chk("mid_rst_re_c2", mem_re, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {mem_re, mem_we}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bus_ready", bus_ready, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_rdata", rdata, 0);
    g = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus_ready !== 1'b0) g++;
    end
    chk("mid_rst_no_pulse", g, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_release_ready", req_ready, 1);
    @(negedge clk);
    chk("mid_rst_still_no_pulse", bus_ready, 0);

    post = '{1'b0, 8'h10, 8'h00, 0, 8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 1};
    run_vec(post, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
